// File: rtl/lambda_minus.sv
// Sliding-window lambda metric: windowed correlation minus scaled windowed
// energy, saturated to OUT_W signed, one metric per accepted sample.
module lambda_minus #(
    parameter int L         = 16,
    parameter int FRAME_LEN = 256,
    parameter int IN_W      = 20,
    parameter int RHO_SHIFT = 1,
    parameter int OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         corr_in,
    input  logic [IN_W-1:0]         energy_in,
    output logic                    minus_valid,
    output logic signed [OUT_W-1:0] lambda,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    in_err
);

    localparam int LW = $clog2(L);
    localparam int SW = IN_W + LW;
    localparam int DW = SW + 1;
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic signed [DW-1:0] SAT_MAX = DW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [DW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 r_state;
    logic [IN_W-1:0]        r_dl_c [L];
    logic [IN_W-1:0]        r_dl_e [L];
    logic [SW-1:0]          r_sum_c;
    logic [SW-1:0]          r_sum_e;
    logic [CW-1:0]          r_cnt;
    logic                   r_v1;
    logic                   r_last1;
    logic                   r_v2;
    logic                   r_last2;
    logic signed [DW-1:0]   r_diff;

    logic                   w_acc;
    logic                   w_last;
    logic [SW-1:0]          w_base_c;
    logic [SW-1:0]          w_base_e;
    logic [IN_W-1:0]        w_old_c;
    logic [IN_W-1:0]        w_old_e;
    logic [SW-1:0]          w_sum_c;
    logic [SW-1:0]          w_sum_e;
    logic signed [DW-1:0]   w_diff;
    logic [OUT_W-1:0]       w_sat;

    assign w_acc  = in_valid && (frame_start || r_state == RUN);
    assign w_last = !frame_start && (r_cnt == CW'(FRAME_LEN - 1));
    assign busy   = (r_state == RUN);

    // A frame_start sample sees an empty window: zero base and zero oldest.
    assign w_base_c = frame_start ? '0 : r_sum_c;
    assign w_base_e = frame_start ? '0 : r_sum_e;
    assign w_old_c  = frame_start ? '0 : r_dl_c[L-1];
    assign w_old_e  = frame_start ? '0 : r_dl_e[L-1];
    assign w_sum_c  = w_base_c + SW'(corr_in) - SW'(w_old_c);
    assign w_sum_e  = w_base_e + SW'(energy_in) - SW'(w_old_e);

    assign w_diff = $signed({1'b0, r_sum_c})
                  - $signed({1'b0, r_sum_e >> RHO_SHIFT});

    always_comb begin
        w_sat = r_diff[OUT_W-1:0];
        if (r_diff > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (r_diff < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            in_err      <= 1'b0;
            r_sum_c     <= '0;
            r_sum_e     <= '0;
            for (int i = 0; i < L; i++) begin
                r_dl_c[i] <= '0;
                r_dl_e[i] <= '0;
            end
            r_v1        <= 1'b0;
            r_last1     <= 1'b0;
            r_v2        <= 1'b0;
            r_last2     <= 1'b0;
            r_diff      <= '0;
            minus_valid <= 1'b0;
            frame_done  <= 1'b0;
            lambda      <= '0;
        end else begin
            if (frame_start) begin
                r_state <= RUN;
                r_cnt   <= in_valid ? CW'(1) : '0;
                in_err  <= 1'b0;
            end else if (w_acc) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (in_valid) begin
                in_err <= 1'b1;
            end

            if (w_acc) begin
                r_dl_c[0] <= corr_in;
                r_dl_e[0] <= energy_in;
                for (int i = 1; i < L; i++) begin
                    r_dl_c[i] <= frame_start ? '0 : r_dl_c[i-1];
                    r_dl_e[i] <= frame_start ? '0 : r_dl_e[i-1];
                end
                r_sum_c <= w_sum_c;
                r_sum_e <= w_sum_e;
            end else if (frame_start) begin
                for (int i = 0; i < L; i++) begin
                    r_dl_c[i] <= '0;
                    r_dl_e[i] <= '0;
                end
                r_sum_c <= '0;
                r_sum_e <= '0;
            end

            // Restart drops anything still in flight from the old frame.
            r_v1    <= w_acc;
            r_last1 <= w_acc && w_last;
            r_v2    <= r_v1 && !frame_start;
            r_last2 <= r_last1 && !frame_start;
            if (r_v1) begin
                r_diff <= w_diff;
            end

            minus_valid <= r_v2 && !frame_start;
            frame_done  <= r_v2 && r_last2 && !frame_start;
            if (r_v2 && !frame_start) begin
                lambda <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_lambda_minus.sv
// Bench for lambda_minus: directed frames plus random traffic, checked
// cycle by cycle against a window/queue model of the metric.
module tb_lambda_minus;

    localparam int L  = 16;
    localparam int FL = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_start;
    logic               in_valid;
    logic [19:0]        corr_in;
    logic [19:0]        energy_in;
    logic               minus_valid;
    logic signed [15:0] lambda;
    logic               frame_done;
    logic               busy;
    logic               in_err;

    lambda_minus dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .corr_in    (corr_in),
        .energy_in  (energy_in),
        .minus_valid(minus_valid),
        .lambda     (lambda),
        .frame_done (frame_done),
        .busy       (busy),
        .in_err     (in_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int lam;
        bit done;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    ent_t pend[$];
    int   win_c[$];
    int   win_e[$];
    int   obs[$];
    bit   m_run = 0;
    bit   m_err = 0;
    int   m_cnt = 0;
    int   m_last = 0;
    int   ndone = 0;
    int   fs_cyc = 0;
    int   first_mv = -1;

    task automatic chk(string tag, logic signed [31:0] got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic accept(int c, int e);
        int sc = 0;
        int se = 0;
        ent_t t;
        win_c.push_back(c);
        win_e.push_back(e);
        if (win_c.size() > L) begin
            void'(win_c.pop_front());
            void'(win_e.pop_front());
        end
        foreach (win_c[i]) sc += win_c[i];
        foreach (win_e[i]) se += win_e[i];
        t.due  = cyc + 3;
        t.lam  = sat(sc - (se / 2));
        t.done = (m_cnt == FL - 1);
        pend.push_back(t);
        m_cnt++;
        if (t.done) begin
            m_run = 0;
            m_cnt = 0;
        end
    endtask

    task automatic step(bit rs, bit fs, bit v, int c, int e);
        bit exp_mv;
        int exp_l;
        bit exp_d;
        @(posedge clk);
        #1;
        exp_mv = 0;
        exp_d  = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_mv = 1;
            m_last = pend[0].lam;
            exp_d  = pend[0].done;
            void'(pend.pop_front());
        end
        exp_l = m_last;
        chk("minus_valid", minus_valid, int'(exp_mv));
        chk("lambda", lambda, exp_l);
        chk("frame_done", frame_done, int'(exp_d));
        chk("busy", busy, int'(m_run));
        chk("in_err", in_err, int'(m_err));
        if (minus_valid) begin
            obs.push_back(int'(lambda));
            if (first_mv < 0) first_mv = cyc;
        end
        if (frame_done) ndone++;

        rst         = rs;
        frame_start = fs;
        in_valid    = v;
        corr_in     = 20'(c);
        energy_in   = 20'(e);
        if (fs) fs_cyc = cyc;

        if (rs) begin
            pend.delete();
            win_c.delete();
            win_e.delete();
            m_run  = 0;
            m_err  = 0;
            m_cnt  = 0;
            m_last = 0;
        end else if (fs) begin
            pend.delete();
            win_c.delete();
            win_e.delete();
            m_cnt = 0;
            m_err = 0;
            m_run = 1;
            if (v) accept(c, e);
        end else if (v && m_run) begin
            accept(c, e);
        end else if (v) begin
            m_err = 1;
        end
        cyc++;
    endtask

    task automatic clr_obs();
        obs.delete();
        ndone    = 0;
        first_mv = -1;
    endtask

    task automatic drain();
        repeat (6) step(0, 0, 0, 0, 0);
    endtask

    task automatic run_frame(int c, int e, bit gap);
        step(0, 1, 1, c, e);
        for (int i = 1; i < FL; i++) begin
            if (gap) step(0, 0, 0, 0, 0);
            step(0, 0, 1, c, e);
        end
        drain();
    endtask

    task automatic ramp_checks(string p);
        chk({p, "_n"}, obs.size(), 256);
        chk({p, "_first"}, obs[0], 100);
        chk({p, "_out2"}, obs[1], 200);
        chk({p, "_out16"}, obs[15], 1600);
        chk({p, "_out17"}, obs[16], 1600);
        chk({p, "_out256"}, obs[255], 1600);
        chk({p, "_done"}, ndone, 1);
        chk({p, "_lat"}, first_mv - fs_cyc, 3);
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        corr_in     = '0;
        energy_in   = '0;
        repeat (2) @(posedge clk);

        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 5);
        drain();

        clr_obs();
        run_frame(100, 0, 0);
        ramp_checks("ramp");

        clr_obs();
        run_frame(0, 64, 0);
        chk("neg_first", obs[0], -32);
        chk("neg_steady", obs[255], -512);

        clr_obs();
        run_frame(1048575, 0, 0);
        chk("sat_hi", obs[255], 32767);
        clr_obs();
        run_frame(0, 1048575, 0);
        chk("sat_lo", obs[255], -32768);

        clr_obs();
        run_frame(10, 0, 1);
        chk("gap_n", obs.size(), 256);
        chk("gap_out1", obs[0], 10);
        chk("gap_out16", obs[15], 160);
        chk("gap_out256", obs[255], 160);

        clr_obs();
        step(0, 1, 1, 7, 2);
        for (int i = 1; i < 300; i++) step(0, 0, 1, 7, 2);
        drain();
        chk("ovr_n", obs.size(), 256);
        chk("ovr_done", ndone, 1);
        chk("ovr_err", in_err, 1);

        clr_obs();
        step(0, 1, 1, 5, 0);
        for (int i = 1; i < 100; i++) step(0, 0, 1, 5, 0);
        chk("abort_err", in_err, 0);
        run_frame(3, 0, 0);
        chk("abort_n", obs.size(), 98 + 256);
        chk("abort_done", ndone, 1);
        chk("abort_restart", obs[98], 3);

        clr_obs();
        step(0, 1, 1, 100, 0);
        for (int i = 1; i < 50; i++) step(0, 0, 1, 100, 0);
        step(1, 0, 1, 100, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_mv", minus_valid, 0);
        chk("rst_lambda", lambda, 0);
        chk("rst_busy", busy, 0);
        clr_obs();
        drain();
        chk("rst_quiet", obs.size(), 0);
        run_frame(100, 0, 0);
        ramp_checks("rst_ramp");

        step(0, 1, 1, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            bit fs;
            bit v;
            int c;
            int e;
            rs = ($urandom_range(0, 1499) == 0);
            fs = ($urandom_range(0, 399) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                c = int'($urandom_range(0, 1048575));
                e = int'($urandom_range(0, 1048575));
            end else begin
                c = int'($urandom_range(0, 3000));
                e = int'($urandom_range(0, 6000));
            end
            if (!m_run && $urandom_range(0, 19) == 0) fs = 1;
            step(rs, fs, v, c, e);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lambda_minus.md
Name: lambda_minus

Overview:
- Upstream neighbour of the argmax stage; produces the per-candidate metric lambda(theta) consumed as `lambda` / `minus_valid`.
- Takes per-sample correlation-magnitude and energy terms and accumulates each over a sliding window of L samples.
- Outputs the saturated difference lambda = sum_corr − (sum_energy >>> RHO_SHIFT).
- Emits exactly FRAME_LEN metrics per frame, so the downstream 256-deep buffer holds one full frame when the frame completes.

Parameters:
- L, 16, sliding window length in samples; power of two, 2..64.
- FRAME_LEN, 256, number of samples accepted (and lambdas emitted) per frame.
- IN_W, 20, width of the unsigned corr_in / energy_in terms.
- RHO_SHIFT, 1, right shift applied to the energy sum (rho = 2^-RHO_SHIFT).
- OUT_W, 16, lambda width, signed two's complement.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  single-cycle pulse; opens a new frame
- in_valid  in  1  corr_in/energy_in valid this cycle
- corr_in  in  IN_W  unsigned correlation magnitude
- energy_in  in  IN_W  unsigned energy term
- minus_valid  out  1  lambda valid this cycle
- lambda  out  OUT_W  signed metric
- frame_done  out  1  pulses with the FRAME_LEN-th minus_valid of a frame
- busy  out  1  high while state==RUN
- in_err  out  1  sticky; set by in_valid while IDLE, cleared by frame_start or rst

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state=IDLE.
  - Sums 0, delay line cleared, sample count 0, pipeline valid bits 0.
- FSM states: IDLE, RUN.
  - IDLE→RUN on frame_start.
  - RUN→IDLE on the cycle the FRAME_LEN-th sample is accepted (in_valid && count==FRAME_LEN−1).
  - frame_start in RUN restarts the frame and stays in RUN.
- Sample acceptance: a sample is accepted when state==RUN && in_valid, or when frame_start && in_valid in the same cycle.
  - frame_start has priority: the sample on that cycle is sample 0 of the new frame.
- in_valid in IDLE without frame_start: sample dropped, in_err set.
- frame_start actions (same cycle):
  - Clears sums, delay line and count; clears in_err.
  - Clears pipeline valid bits: in-flight samples of the aborted frame are never emitted, and no frame_done is produced for the aborted frame.
- Sliding window:
  - Delay line of L entries per term.
  - On acceptance: sum += new − oldest; the delay line shifts.
  - Sums are unsigned, IN_W+log2(L) bits (24 at defaults); no overflow is possible.
  - The first L−1 samples of a frame produce partial-window sums, because the delay line starts at zero.
- No input gaps affect results: the window advances only on accepted samples; idle cycles hold all state.
- Pipeline, 3 registered stages:
  - S1: window update.
  - S2: diff = sum_corr − (sum_energy >> RHO_SHIFT), signed, IN_W+log2(L)+1 bits.
  - S3: saturate diff to OUT_W signed, clamped to [−32768, 32767].
- Latency: accepted sample at cycle t → minus_valid=1 with its lambda at t+3.
- Throughput: one sample per cycle.
- lambda holds its last value while minus_valid=0.
- frame_done is asserted on the same cycle as the minus_valid of sample FRAME_LEN−1.
- Extra in_valid after FRAME_LEN samples (state IDLE): dropped, in_err set.
- busy falls the cycle after the last sample is accepted, even though that sample's result is still in the pipeline.

Test Plan:
1. Ramp: frame_start with in_valid, then corr_in=100, energy_in=0 for 256 consecutive cycles (RHO_SHIFT=1) → lambda = 100, 200, …, 1600 for the first 16 outputs, then 1600 for outputs 17..256. First minus_valid 3 cycles after frame_start. frame_done with output 256. Exactly 256 minus_valid pulses.
2. Negative metric: corr_in=0, energy_in=64 → steady-state lambda = −(1024>>1) = −512.
3. Saturation: corr_in=1048575, energy_in=0 → steady-state lambda = 32767. corr_in=0, energy_in=1048575 → lambda = −32768.
4. Gapped input: in_valid high on alternate cycles, corr_in=10 → same value sequence as the gap-free case (10, 20, …, 160, then 160). Each lambda appears 3 cycles after its sample.
5. Overrun and abort:
   - Drive 300 in_valid after frame_start → 256 outputs, one frame_done, in_err=1 after sample 257.
   - Then frame_start at sample 100 of the next frame → in_err clears, no frame_done for the aborted frame, window restarts from zero.
6. Reset mid-frame: assert rst at sample 50 → the next cycle all outputs are 0, busy=0, no further minus_valid. A new frame after reset behaves exactly as in test 1.
